// File: rtl/usb_packet_sequencer_pkg.sv
// Shared types and constants for the USB packet sequencer.
package usb_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;
endpackage

// File: rtl/usb_packet_sequencer_if.sv
// Byte/word plumbing between the stock datapath, the sequencer and the USB serial engine.
interface usb_packet_sequencer_if
  import usb_pkg::*;
#(
  parameter int BYTES = 4
) ();
  logic                      output_ready;
  logic [BYTE_W*BYTES-1:0]   average_data;
  logic                      tx_busy;
  logic                      tx_load;
  logic [BYTE_W-1:0]         tx_byte;
  logic                      new_packet;
  logic [BYTE_W-1:0]         rx_byte;
  logic [BYTE_W*BYTES-1:0]   stock_data;
  logic                      data_ready;
  logic                      tx_active;

  modport slave (
    input  output_ready, average_data, tx_busy, new_packet, rx_byte,
    output tx_load, tx_byte, stock_data, data_ready, tx_active
  );

  modport master (
    output output_ready, average_data, tx_busy, new_packet, rx_byte,
    input  tx_load, tx_byte, stock_data, data_ready, tx_active
  );
endinterface

// File: rtl/usb_packet_sequencer_rx_assembler.sv
// Collects BYTES received bytes MSB first into one word; drops a partial word after RX_TIMEOUT idle cycles.
module usb_rx_assembler
  import usb_pkg::*;
#(
  parameter int BYTES      = 4,
  parameter int RX_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_packet,
  input  logic [BYTE_W-1:0]         rx_byte,
  output logic [BYTE_W*BYTES-1:0]   stock_data,
  output logic                      data_ready
);
  localparam int WORD_W = BYTE_W * BYTES;
  localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TMR_W  = $clog2(RX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [WORD_W-1:0] stock_q, stock_d;
  logic              ready_q, ready_d;
  logic              timed_out;
  logic [WORD_W-1:0] base_word;
  logic [CNT_W-1:0]  base_cnt;
  logic [WORD_W-1:0] assembled;

  always_comb begin
    shift_d   = shift_q;
    rx_cnt_d  = rx_cnt_q;
    timer_d   = timer_q;
    stock_d   = stock_q;
    ready_d   = 1'b0;
    timed_out = (rx_cnt_q != '0) && (timer_q == TMR_W'(RX_TIMEOUT - 1));
    // A byte arriving in the timeout cycle starts a fresh word rather than extending the stale one.
    base_word = timed_out ? '0 : shift_q;
    base_cnt  = timed_out ? '0 : rx_cnt_q;
    assembled = (base_word << BYTE_W) | WORD_W'(rx_byte);

    if (new_packet) begin
      timer_d = '0;
      if (base_cnt == LAST_CNT) begin
        stock_d  = assembled;
        ready_d  = 1'b1;
        rx_cnt_d = '0;
        shift_d  = '0;
      end else begin
        shift_d  = assembled;
        rx_cnt_d = base_cnt + CNT_W'(1);
      end
    end else if (rx_cnt_q != '0) begin
      if (timed_out) begin
        rx_cnt_d = '0;
        timer_d  = '0;
        shift_d  = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      rx_cnt_q <= '0;
      timer_q  <= '0;
      stock_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      rx_cnt_q <= rx_cnt_d;
      timer_q  <= timer_d;
      stock_q  <= stock_d;
      ready_q  <= ready_d;
    end
  end

  assign stock_data = stock_q;
  assign data_ready = ready_q;
endmodule

// File: rtl/usb_packet_sequencer.sv
// Serialises averaged words to the USB transmitter MSB first and hands assembled RX words to the stock path.
module usb_packet_sequencer
  import usb_pkg::*;
#(
  parameter int BYTES      = 4,
  parameter int RX_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  usb_packet_sequencer_if.slave  bus
);
  localparam int WORD_W = BYTE_W * BYTES;
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  tx_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] pend_word_q, pend_word_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;

  function automatic logic [BYTE_W-1:0] sel_byte(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
    logic [BYTE_W-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (i == IDX_W'(b)) r = w[BYTE_W*(BYTES-1-b) +: BYTE_W];
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    tx_byte_d   = tx_byte_q;

    case (state_q)
      TX_IDLE: begin
        // A fresh strobe is newer than anything pending, so it wins.
        if (bus.output_ready) begin
          word_d  = bus.average_data;
          pend_d  = 1'b0;
          state_d = TX_LOAD;
        end else if (pend_q) begin
          word_d  = pend_word_q;
          pend_d  = 1'b0;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD:      state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (bus.tx_busy) state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = TX_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (state_q != TX_IDLE && bus.output_ready) begin
      pend_d      = 1'b1;
      pend_word_d = bus.average_data;
    end

    // tx_byte is registered so it holds steady between loads, including after the last byte.
    if (state_d == TX_LOAD) tx_byte_d = sel_byte(word_d, idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      tx_byte_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  assign bus.tx_load   = (state_q == TX_LOAD);
  assign bus.tx_active = (state_q != TX_IDLE);
  assign bus.tx_byte   = tx_byte_q;

  usb_rx_assembler #(
    .BYTES      (BYTES),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .new_packet (bus.new_packet),
    .rx_byte    (bus.rx_byte),
    .stock_data (bus.stock_data),
    .data_ready (bus.data_ready)
  );
endmodule

// File: tb/tb_usb_packet_sequencer.sv
// Directed bench for usb_packet_sequencer: TX serialisation, pending words, RX assembly, timeout and reset.
module tb_usb_packet_sequencer;
  import usb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  usb_packet_sequencer_if #(.BYTES(4)) bus ();

  usb_packet_sequencer #(.BYTES(4), .RX_TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          busy_cnt    = 0;
  int          dr_count    = 0;
  int          dr_before;
  logic [31:0] last_stock  = '0;
  logic [7:0]  txq[$];

  // Transmitter model: busy for 10 cycles after every load.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt    = 0;
      bus.tx_busy = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        bus.tx_busy = (busy_cnt != 0);
      end
      if (bus.tx_load) begin
        txq.push_back(bus.tx_byte);
        $display("tx byte %h", bus.tx_byte);
        busy_cnt    = 10;
        bus.tx_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.data_ready) begin
      dr_count++;
      last_stock = bus.stock_data;
      $display("rx word %h", bus.stock_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe_tx(input logic [31:0] w);
    @(negedge clk);
    bus.output_ready = 1'b1;
    bus.average_data = w;
    @(negedge clk);
    bus.output_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.new_packet = 1'b1;
    bus.rx_byte    = b;
    @(negedge clk);
    bus.new_packet = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int c;
    c = 0;
    while (!((txq.size() >= n) && !bus.tx_active) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(c < 2000), 32'd1);
  endtask

  task automatic check_tx_word(input string tag, input logic [31:0] w, input int base);
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      got = (txq.size() > base + i) ? txq[base + i] : 8'hxx;
      check(tag, {24'h0, got}, {24'h0, w[8*(3-i) +: 8]});
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.output_ready = 1'b0;
    bus.average_data = '0;
    bus.new_packet   = 1'b0;
    bus.rx_byte      = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_load",    {31'h0, bus.tx_load},    32'd0);
    check("rst_tx_active",  {31'h0, bus.tx_active},  32'd0);
    check("rst_data_ready", {31'h0, bus.data_ready}, 32'd0);
    check("rst_stock",      bus.stock_data,          32'h0);
    check("rst_tx_byte",    {24'h0, bus.tx_byte},    32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic TX with one-cycle latency to the first load
    strobe_tx(32'hDEADBEEF);
    check("tx_first_load",  {31'h0, bus.tx_load}, 32'd1);
    check("tx_first_byte",  {24'h0, bus.tx_byte}, 32'hDE);
    @(negedge clk);
    check("tx_load_1cycle", {31'h0, bus.tx_load}, 32'd0);
    wait_tx(4, "tx_basic_timeout");
    check("tx_basic_count", txq.size(), 32'd4);
    check_tx_word("tx_basic", 32'hDEADBEEF, 0);
    check("tx_byte_hold",   {24'h0, bus.tx_byte}, 32'hEF);

    // Basic RX with 3-cycle gaps
    dr_before = dr_count;
    send_rx(8'h12, 3);
    send_rx(8'h34, 3);
    send_rx(8'h56, 3);
    check("rx_no_early_dr", dr_count - dr_before, 32'd0);
    @(negedge clk);
    bus.new_packet = 1'b1;
    bus.rx_byte    = 8'h78;
    @(negedge clk);
    bus.new_packet = 1'b0;
    check("rx_dr_pulse",    {31'h0, bus.data_ready}, 32'd1);
    check("rx_stock",       bus.stock_data,          32'h12345678);
    @(negedge clk);
    check("rx_dr_1cycle",   {31'h0, bus.data_ready}, 32'd0);
    repeat (5) @(negedge clk);
    check("rx_dr_count",    dr_count - dr_before,    32'd1);

    // Pending: newest strobe during an active word wins
    txq.delete();
    strobe_tx(32'h11111111);
    repeat (5) @(negedge clk);
    strobe_tx(32'h22222222);
    repeat (15) @(negedge clk);
    strobe_tx(32'h33333333);
    wait_tx(8, "pend_timeout");
    repeat (5) @(negedge clk);
    check("pend_count", txq.size(), 32'd8);
    check_tx_word("pend_w0", 32'h11111111, 0);
    check_tx_word("pend_w1", 32'h33333333, 4);

    // RX timeout discards a partial word
    dr_before = dr_count;
    send_rx(8'h01, 1);
    send_rx(8'h02, 300);
    check("tmo_no_dr", dr_count - dr_before, 32'd0);
    send_rx(8'hAA, 1);
    send_rx(8'hBB, 1);
    send_rx(8'hCC, 1);
    send_rx(8'hDD, 3);
    check("tmo_dr_count", dr_count - dr_before, 32'd1);
    check("tmo_stock",    last_stock,           32'hAABBCCDD);

    // Reset in the middle of TX byte 2 with a partial RX word held
    send_rx(8'h55, 1);
    send_rx(8'h66, 1);
    send_rx(8'h77, 1);
    txq.delete();
    strobe_tx(32'h01020304);
    begin
      int c;
      c = 0;
      while (txq.size() < 2 && c < 500) begin
        @(negedge clk);
        c++;
      end
      check("mid_reach_byte2", 32'(c < 500), 32'd1);
    end
    rst = 1'b1;
    #1;
    check("mid_tx_active",  {31'h0, bus.tx_active},  32'd0);
    check("mid_tx_load",    {31'h0, bus.tx_load},    32'd0);
    check("mid_tx_byte",    {24'h0, bus.tx_byte},    32'h0);
    check("mid_stock",      bus.stock_data,          32'h0);
    check("mid_data_ready", {31'h0, bus.data_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    txq.delete();
    strobe_tx(32'hDEADBEEF);
    wait_tx(4, "post_rst_tx_timeout");
    check("post_rst_tx_count", txq.size(), 32'd4);
    check_tx_word("post_rst_tx", 32'hDEADBEEF, 0);
    dr_before = dr_count;
    send_rx(8'h12, 3);
    send_rx(8'h34, 3);
    send_rx(8'h56, 3);
    send_rx(8'h78, 3);
    check("post_rst_dr_count", dr_count - dr_before, 32'd1);
    check("post_rst_stock",    last_stock,           32'h12345678);

    // Concurrent TX and RX
    txq.delete();
    dr_before = dr_count;
    strobe_tx(32'hCAFEF00D);
    send_rx(8'h0B, 2);
    send_rx(8'hAD, 2);
    send_rx(8'hC0, 2);
    send_rx(8'hDE, 2);
    wait_tx(4, "conc_tx_timeout");
    repeat (3) @(negedge clk);
    check("conc_tx_count",  txq.size(),           32'd4);
    check_tx_word("conc_tx", 32'hCAFEF00D, 0);
    check("conc_dr_count",  dr_count - dr_before, 32'd1);
    check("conc_stock",     last_stock,           32'h0BADC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
